// File: rtl/dadda_mul_arbiter.sv
// Round-robin arbiter sharing one combinational 4x4 Dadda multiplier among NUM_REQ requesters.
// Operands (S1) and tagged product (S2) are registered; valid/ready backpressure throughout.
module dadda_multiplier (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [3:0] pp [4];
  logic s1_3, c1_4, s1_4, c1_5;
  logic s2_2, c2_3, s2_3, c2_4, s2_4, c2_5, s2_5, c2_6;
  logic [7:0] row_x, row_y;

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // pp[i][j] = b[i] & a[j], weight i+j
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pp
      assign pp[gi] = a_i & {4{b_i[gi]}};
    end
  endgenerate

  // Reduce column heights to 3, then to 2, before the final carry-propagate add
  assign {c1_4, s1_3} = ha(pp[0][3], pp[1][2]);
  assign {c1_5, s1_4} = ha(pp[1][3], pp[2][2]);

  assign {c2_3, s2_2} = ha(pp[0][2], pp[1][1]);
  assign {c2_4, s2_3} = fa(s1_3, pp[2][1], pp[3][0]);
  assign {c2_5, s2_4} = fa(s1_4, pp[3][1], c1_4);
  assign {c2_6, s2_5} = fa(pp[2][3], pp[3][2], c1_5);

  assign row_x = {1'b0, pp[3][3], s2_5, s2_4, s2_3, s2_2, pp[0][1], pp[0][0]};
  assign row_y = {1'b0, c2_6, c2_5, c2_4, c2_3, pp[2][0], pp[1][0], 1'b0};
  assign p_o   = row_x + row_y;
endmodule

module dadda_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_product,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);
  logic            s1_valid_q, s1_valid_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic [3:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [7:0]      rsp_product_q, rsp_product_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic            s2_load, s1_load;
  logic            grant_valid, accept;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   scan_idx, rr_inc;
  logic [3:0]      op_a [NUM_REQ];
  logic [3:0]      op_b [NUM_REQ];
  logic [7:0]      product;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ops
      assign op_a[gi] = req_a[4*gi +: 4];
      assign op_b[gi] = req_b[4*gi +: 4];
    end
  endgenerate

  dadda_multiplier u_mul (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (product)
  );

  assign s2_load = !rsp_valid_q || rsp_ready;
  assign s1_load = !s1_valid_q || s2_load;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_valid && req_valid[scan_idx[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  assign accept = grant_valid && s1_load;
  assign rr_inc = {1'b0, grant_idx} + (ID_W+1)'(1);

  always_comb begin
    req_ready = '0;
    if (!rst && accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    rr_ptr_d   = rr_ptr_q;
    if (s1_load) begin
      s1_valid_d = grant_valid;
      if (grant_valid) begin
        s1_id_d  = grant_idx;
        s1_a_d   = op_a[grant_idx];
        s1_b_d   = op_b[grant_idx];
        rr_ptr_d = (rr_inc == (ID_W+1)'(NUM_REQ)) ? '0 : rr_inc[ID_W-1:0];
      end
    end
  end

  // Result stage keeps its last id/product when it drains into a bubble
  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    op_count_d    = op_count_q;
    if (s2_load) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_id_d      = s1_id_q;
        rsp_product_d = product;
      end
    end
    if (rsp_valid_q && rsp_ready) begin
      op_count_d = op_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_id_q       <= '0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      rr_ptr_q      <= '0;
      op_count_q    <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_id_q       <= s1_id_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      rr_ptr_q      <= rr_ptr_d;
      op_count_q    <= op_count_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
  assign busy        = s1_valid_q || rsp_valid_q;
  assign op_count    = op_count_q;
endmodule

// File: doc/dadda_mul_arbiter.md
Name: dadda_mul_arbiter

Overview:
- Shares one 4x4 unsigned `dadda_multiplier` datapath among NUM_REQ requesters.
- Arbitration is round-robin.
- Operands and product are registered in a 2-stage pipeline with valid/ready backpressure.
- Sits between the requesting engines and the combinational Dadda multiplier. Sustains one multiply per cycle and tags each result with its requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of the requester ID; must equal ceil(log2(NUM_REQ)), minimum 1
- CNT_W, 16, width of the completed-operation counter

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_a  input  4*NUM_REQ  operand A; requester i uses bits [4i+3:4i]
- req_b  input  4*NUM_REQ  operand B; requester i uses bits [4i+3:4i]
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  ID_W  index of the requester that owns the result
- rsp_product  output  8  unsigned product a*b
- busy  output  1  high when any pipeline stage holds valid data
- op_count  output  CNT_W  number of results handed off (rsp_valid & rsp_ready)

Behaviour:
- Reset (async, immediate):
  - s1_valid=0, rsp_valid=0, rsp_id=0, rsp_product=0.
  - rr_ptr=0, op_count=0, busy=0.
  - req_ready=0 while rst is high.
  - In-flight operations are discarded, with no partial response.
- Stage S1 (operand register):
  - Holds s1_valid, s1_id, s1_a, s1_b.
  - Feeds one internal `dadda_multiplier` instance combinationally.
- Stage S2 (output register):
  - Holds rsp_valid, rsp_id, rsp_product.
  - rsp_product is loaded from the multiplier output.
- Advance rules:
  - s2_load = !rsp_valid | rsp_ready.
  - s1_load = !s1_valid | s2_load.
- On s2_load:
  - rsp_valid <= s1_valid.
  - If s1_valid: rsp_id <= s1_id and rsp_product <= product.
  - If !s1_valid, rsp_id and rsp_product hold their values.
- Arbitration (combinational):
  - Scan the requesters from rr_ptr upward, modulo NUM_REQ.
  - The first i with req_valid[i]=1 is granted.
  - req_ready[grant]=s1_load; all other req_ready bits are 0.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept (req_valid[i] & req_ready[i] at a rising edge):
  - S1 <= {1, i, a_i, b_i}.
  - rr_ptr <= (i+1) mod NUM_REQ.
- When s1_load is high and no requester is valid: s1_valid <= 0 and rr_ptr holds.
- Latency: a request accepted at edge k presents rsp_valid=1 after edge k+1, i.e. 2-cycle latency.
- Throughput: 1 result per cycle when rsp_ready stays high.
- Backpressure: while rsp_valid & !rsp_ready:
  - S2 holds.
  - S1 holds if it is full.
  - If S1 is empty, exactly one more request is accepted, then all req_ready bits go to 0.
  - No result is ever dropped or duplicated.
- Simultaneous events: when S2 hands off and S1 loads on the same edge, both happen. There is no bubble.
- Requester protocol: a requester holds req_valid and its operands stable until accepted. The block does not check this.
- Arithmetic: unsigned 4x4 to 8 bits, with no truncation; 15*15=225.
- op_count:
  - Increments on each rsp_valid & rsp_ready.
  - Wraps from 2^CNT_W-1 to 0.
- busy = s1_valid | rsp_valid.
- Fairness: a requester that is continuously valid is granted within NUM_REQ accepts.

Test Plan:
- Reset check: assert rst mid-operation with S1 and S2 full -> rsp_valid=0, busy=0, op_count=0, req_ready=0 immediately (asynchronous). After release, first grant goes to requester 0.
- Single request: req 2 with a=3, b=5, rsp_ready=1 -> req_ready=4'b0100 for one cycle. Two cycles later rsp_valid=1, rsp_id=2, rsp_product=15, and op_count becomes 1 after handoff.
- All four valid for 4 cycles (a=i+1, b=i+10), rsp_ready=1 -> responses on consecutive cycles in order:
  - id0: 1*10=10
  - id1: 2*11=22
  - id2: 3*12=36
  - id3: 4*13=52
- Round-robin: req1 and req3 held valid continuously, rr_ptr=0 -> grant sequence 1,3,1,3 with no starvation.
- Backpressure: stream from req0 with rsp_ready=0 for 5 cycles -> exactly 2 requests are accepted, then req_ready=0. After rsp_ready returns to 1, both results appear in order with no loss.
- Exhaustive: all 256 (a,b) pairs pushed through requesters in rotation -> every rsp_product equals a*b (0..225), rsp_id matches the source, and op_count=256.
